// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard, flush and memory-wait stall control for the 5-stage pipeline
// Optional stall-cycle statistics counter is built when HAZARD_STATS_EN is defined.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        rst,
   input  logic [3:0]  decode_rs,
   input  logic [3:0]  decode_rt,
   input  logic        decode_uses_rs,
   input  logic        decode_uses_rt,
   input  logic [3:0]  execute_rd,
   input  logic        execute_regwrite,
   input  logic        execute_mem2reg,
   input  logic        branch_taken,
   input  logic        mem_access,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        pc_write,
   output logic        fd_write,
   output logic        de_write,
   output logic        em_write,
   output logic        mw_write,
   output logic        fd_flush,
   output logic        de_flush,
   output logic        mem_err,
   output logic [15:0] stall_cycles
);

   typedef enum logic {ST_RUN, ST_WAIT} state_t;

   localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

   state_t      state, state_nxt;
   logic [15:0] wait_cnt, wait_cnt_nxt;
   logic        freeze;
   logic        set_err;
   logic        load_use;

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      freeze       = 1'b0;
      set_err      = 1'b0;
      case (state)
         ST_RUN: begin
            if (mem_access && !mem_ack) begin
               freeze       = 1'b1;
               state_nxt    = ST_WAIT;
               wait_cnt_nxt = 16'd1;
            end
         end
         ST_WAIT: begin
            if (mem_ack) begin
               state_nxt    = ST_RUN;
               wait_cnt_nxt = 16'd0;
            end else if (wait_cnt < TIMEOUT) begin
               freeze       = 1'b1;
               wait_cnt_nxt = wait_cnt + 16'd1;
            end else begin
               // Give up on the access: let the instruction advance without data.
               set_err      = 1'b1;
               state_nxt    = ST_RUN;
               wait_cnt_nxt = 16'd0;
            end
         end
         default: begin
            state_nxt    = ST_RUN;
            wait_cnt_nxt = 16'd0;
         end
      endcase
   end

   // R0 reads as zero, so a load targeting it can never create a dependency.
   assign load_use = execute_mem2reg && execute_regwrite && (execute_rd != 4'd0) &&
                     ((decode_uses_rs && (decode_rs == execute_rd)) ||
                      (decode_uses_rt && (decode_rt == execute_rd)));

   always_comb begin
      mem_req  = 1'b0;
      pc_write = 1'b0;
      fd_write = 1'b0;
      de_write = 1'b0;
      em_write = 1'b0;
      mw_write = 1'b0;
      fd_flush = 1'b0;
      de_flush = 1'b0;
      if (rst) begin
         mem_req = mem_access;
         if (!freeze) begin
            pc_write = 1'b1;
            fd_write = 1'b1;
            de_write = 1'b1;
            em_write = 1'b1;
            mw_write = 1'b1;
            if (branch_taken) begin
               fd_flush = 1'b1;
               de_flush = 1'b1;
            end else if (load_use) begin
               pc_write = 1'b0;
               fd_write = 1'b0;
               de_flush = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state    <= ST_RUN;
         wait_cnt <= 16'd0;
         mem_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (set_err) begin
            mem_err <= 1'b1;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         stall_cycles <= 16'd0;
      end else if (!pc_write && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end
`else
   assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized checks of pipe_hazard_ctrl against a reference model
module tb_pipe_hazard_ctrl;

   localparam int T = 4;

   logic        clock;
   logic        rst;
   logic [3:0]  decode_rs, decode_rt, execute_rd;
   logic        decode_uses_rs, decode_uses_rt;
   logic        execute_regwrite, execute_mem2reg;
   logic        branch_taken, mem_access, mem_ack;
   logic        mem_req, pc_write, fd_write, de_write, em_write, mw_write;
   logic        fd_flush, de_flush, mem_err;
   logic [15:0] stall_cycles;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: an access may stay frozen for at most T cycles in total.
   bit outstanding;
   int frozen_used;
   bit err_m;
   int stalls_m;

   logic obs_pc, obs_fdf, obs_def, obs_req, obs_err;
   logic [15:0] obs_stall;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
      .clock            (clock),
      .rst              (rst),
      .decode_rs        (decode_rs),
      .decode_rt        (decode_rt),
      .decode_uses_rs   (decode_uses_rs),
      .decode_uses_rt   (decode_uses_rt),
      .execute_rd       (execute_rd),
      .execute_regwrite (execute_regwrite),
      .execute_mem2reg  (execute_mem2reg),
      .branch_taken     (branch_taken),
      .mem_access       (mem_access),
      .mem_ack          (mem_ack),
      .mem_req          (mem_req),
      .pc_write         (pc_write),
      .fd_write         (fd_write),
      .de_write         (de_write),
      .em_write         (em_write),
      .mw_write         (mw_write),
      .fd_flush         (fd_flush),
      .de_flush         (de_flush),
      .mem_err          (mem_err),
      .stall_cycles     (stall_cycles)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_idle();
      rst              = 1'b1;
      decode_rs        = 4'd0;
      decode_rt        = 4'd0;
      decode_uses_rs   = 1'b0;
      decode_uses_rt   = 1'b0;
      execute_rd       = 4'd0;
      execute_regwrite = 1'b0;
      execute_mem2reg  = 1'b0;
      branch_taken     = 1'b0;
      mem_access       = 1'b0;
      mem_ack          = 1'b0;
   endtask

   // Entered just after a rising edge with inputs applied; checks mid-cycle, then advances the model.
   task automatic cycle();
      bit pend, frz, tmo, lu;
      logic [4:0] exp_we;
      logic [1:0] exp_fl;
      #4;
      if (!rst) begin
         outstanding = 1'b0;
         frozen_used = 0;
         err_m       = 1'b0;
         stalls_m    = 0;
      end
      lu = execute_mem2reg && execute_regwrite && (execute_rd != 0) &&
           ((decode_uses_rs && decode_rs == execute_rd) || (decode_uses_rt && decode_rt == execute_rd));
      pend = outstanding ? !mem_ack : (mem_access && !mem_ack);
      frz  = pend && (frozen_used < T);
      tmo  = outstanding && !mem_ack && (frozen_used >= T);
      exp_we = 5'b00000;
      exp_fl = 2'b00;
      if (rst && !frz) begin
         exp_we = 5'b11111;
         if (branch_taken) exp_fl = 2'b11;
         else if (lu) begin
            exp_we = 5'b00111;
            exp_fl = 2'b01;
         end
      end
      obs_pc    = pc_write;
      obs_fdf   = fd_flush;
      obs_def   = de_flush;
      obs_req   = mem_req;
      obs_err   = mem_err;
      obs_stall = stall_cycles;
      chk("mem_req", 32'(mem_req), 32'(rst && mem_access));
      chk("write_en", 32'({pc_write, fd_write, de_write, em_write, mw_write}), 32'(exp_we));
      chk("flush", 32'({fd_flush, de_flush}), 32'(exp_fl));
      chk("mem_err", 32'(mem_err), 32'(err_m));
      chk("stall_cycles", 32'(stall_cycles), 32'(stalls_m));
      @(posedge clock);
      if (rst) begin
         if (frz) begin
            outstanding = 1'b1;
            frozen_used++;
         end else begin
            if (tmo) err_m = 1'b1;
            outstanding = 1'b0;
            frozen_used = 0;
         end
`ifdef HAZARD_STATS_EN
         if (!exp_we[4] && stalls_m < 65535) stalls_m++;
`endif
      end
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      cycle();
      set_idle();
   endtask

   initial begin
      set_idle();
      rst = 1'b0;
      outstanding = 1'b0;
      frozen_used = 0;
      err_m = 1'b0;
      stalls_m = 0;
      @(posedge clock);
      #1;
      cycle();
      chk("reset_pc_write", 32'(obs_pc), 32'd0);
      chk("reset_mem_req", 32'(obs_req), 32'd0);
      set_idle();

      // Load-use on rs, then the following normal cycle, then the R0 case.
      execute_mem2reg = 1'b1; execute_regwrite = 1'b1; execute_rd = 4'd3;
      decode_rs = 4'd3; decode_uses_rs = 1'b1;
      cycle();
      chk("lu_pc_write", 32'(obs_pc), 32'd0);
      chk("lu_de_flush", 32'(obs_def), 32'd1);
      set_idle();
      cycle();
      chk("lu_next_pc_write", 32'(obs_pc), 32'd1);
      execute_mem2reg = 1'b1; execute_regwrite = 1'b1; execute_rd = 4'd0;
      decode_rs = 4'd0; decode_uses_rs = 1'b1;
      cycle();
      chk("lu_r0_pc_write", 32'(obs_pc), 32'd1);

      // Memory access acked three cycles after it starts.
      pulse_reset();
      mem_access = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mem_ack = (i == 3);
         cycle();
         chk("memwait_pc_write", 32'(obs_pc), (i < 3) ? 32'd0 : 32'd1);
         chk("memwait_mem_req", 32'(obs_req), 32'd1);
      end
      set_idle();
      cycle();
`ifdef HAZARD_STATS_EN
      chk("memwait_stalls", 32'(obs_stall), 32'd3);
`endif

      // Timeout: never acked.
      mem_access = 1'b1;
      for (int i = 0; i < T + 1; i++) begin
         cycle();
         chk("timeout_pc_write", 32'(obs_pc), (i < T) ? 32'd0 : 32'd1);
      end
      set_idle();
      cycle();
      chk("timeout_mem_err", 32'(obs_err), 32'd1);
      cycle();
      chk("mem_err_sticky", 32'(obs_err), 32'd1);

      // Branch held during a freeze flushes only in the ack cycle.
      pulse_reset();
      mem_access = 1'b1; branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mem_ack = (i == 2);
         cycle();
         chk("br_wait_fd_flush", 32'(obs_fdf), (i == 2) ? 32'd1 : 32'd0);
         chk("br_wait_de_flush", 32'(obs_def), (i == 2) ? 32'd1 : 32'd0);
      end
      set_idle();

      // Branch and load-use together: branch wins.
      branch_taken = 1'b1; execute_mem2reg = 1'b1; execute_regwrite = 1'b1;
      execute_rd = 4'd5; decode_rt = 4'd5; decode_uses_rt = 1'b1;
      cycle();
      chk("br_lu_pc_write", 32'(obs_pc), 32'd1);
      chk("br_lu_fd_flush", 32'(obs_fdf), 32'd1);
      set_idle();

      // Reset during the second wait cycle.
      mem_access = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      cycle();
      chk("rst_mid_wait_req", 32'(obs_req), 32'd0);
      set_idle();
      cycle();
      chk("after_rst_pc_write", 32'(obs_pc), 32'd1);
      chk("after_rst_mem_err", 32'(obs_err), 32'd0);
      chk("after_rst_stalls", 32'(obs_stall), 32'd0);

      // Randomized traffic checked against the model.
      for (int i = 0; i < 600; i++) begin
         rst              = ($urandom_range(0, 59) != 0);
         decode_rs        = 4'($urandom_range(0, 3));
         decode_rt        = 4'($urandom_range(0, 3));
         decode_uses_rs   = 1'($urandom_range(0, 1));
         decode_uses_rt   = 1'($urandom_range(0, 1));
         execute_rd       = 4'($urandom_range(0, 3));
         execute_regwrite = ($urandom_range(0, 3) != 0);
         execute_mem2reg  = 1'($urandom_range(0, 1));
         branch_taken     = ($urandom_range(0, 4) == 0);
         mem_access       = ($urandom_range(0, 2) == 0);
         mem_ack          = ($urandom_range(0, 9) < 3);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage 16-bit pipeline. Drives the write-enable and flush inputs of the PC and the fetch/decode, decode/execute, execute/memory and memory/writeback pipeline registers. Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory accesses, with a bounded memory wait and an optional stall-cycle counter.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive wait cycles for one memory access before abort (1..65535)
- clock  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous active-low reset
- decode_rs, decode_rt  input  4 each  source register numbers in decode
- decode_uses_rs, decode_uses_rt  input  1 each  decode instruction reads rs / rt
- execute_rd  input  4  destination register in execute
- execute_regwrite, execute_mem2reg  input  1 each  execute instruction writes a register / is a load
- branch_taken  input  1  execute resolved a taken branch or jump
- mem_access  input  1  memory-stage instruction is a load or store
- mem_ack  input  1  data memory completes the access this cycle
- mem_req  output  1  request to data memory
- pc_write, fd_write, de_write, em_write, mw_write  output  1 each  register write enables (1 = latch)
- fd_flush, de_flush  output  1 each  load a bubble (all-zero control) into that register
- mem_err  output  1  sticky: a memory access timed out
- stall_cycles  output  16  saturating count of cycles with pc_write = 0

## Operation
- States: RUN, WAIT. Wait counter is 16 bits.
- freeze: (state RUN & mem_access & !mem_ack) | (state WAIT & !mem_ack & wait_cnt < MEM_TIMEOUT).
- Load-use hazard: execute_mem2reg & execute_regwrite & execute_rd != 0 & ((decode_uses_rs & decode_rs == execute_rd) | (decode_uses_rt & decode_rt == execute_rd)). R0 is hardwired zero, so it never hazards.
- Output priority, highest first:
  - freeze: all five write enables 0, flushes 0.
  - branch_taken: all write enables 1, fd_flush = de_flush = 1.
  - load-use: pc_write = fd_write = 0, de_flush = 1, other write enables 1.
  - otherwise: all write enables 1, flushes 0.
- mem_req = mem_access in both states; held while frozen.
- RUN -> WAIT when mem_access & !mem_ack; wait_cnt loads 1.
- WAIT -> RUN on mem_ack; the pipeline advances in that same cycle.
- WAIT increments wait_cnt each cycle without mem_ack.
- WAIT with wait_cnt == MEM_TIMEOUT and no ack: set mem_err, release freeze for that cycle (instruction advances, access dropped), return to RUN.
- mem_err is cleared only by reset.

## Timing
- All outputs are combinational from the inputs and registered state; there is no added pipeline latency.
- State, wait_cnt, mem_err and stall_cycles update on the rising clock edge.
- Zero-wait access (mem_ack in the same cycle as mem_access): no freeze, state stays RUN.
- Access with N wait cycles (mem_ack N cycles after mem_access rises, N < MEM_TIMEOUT): exactly N frozen cycles.
- Branch during freeze: the flush is deferred to the first unfrozen cycle, because branch_taken is held by the frozen execute stage.
- Branch and load-use in the same cycle: branch wins, and the dependent instruction is flushed.
- Reset assertion mid-WAIT: state -> RUN, wait_cnt = 0 immediately.
- Reset values while rst = 0:
  - state RUN, wait_cnt 0, mem_err 0, stall_cycles 0.
  - mem_req 0, all write enables 0, flushes 0.

## Configuration
- HAZARD_STATS_EN defined: stall_cycles increments on each clock edge where pc_write = 0 and rst = 1, saturating at 16'hFFFF.
- HAZARD_STATS_EN undefined: the counter is not built and stall_cycles is tied to 0.

## Test plan
- Load-use: execute load rd = 3, decode rs = 3 with uses_rs = 1 -> one cycle of pc_write = 0, fd_write = 0, de_flush = 1; the next cycle is normal. Same stimulus with rd = 0 -> no stall.
- Memory wait: mem_access = 1, mem_ack rises 3 cycles later -> write enables 0 for exactly 3 cycles, mem_req held 1, return to RUN, stall_cycles = 3 (stats on).
- Timeout: MEM_TIMEOUT = 4, mem_ack never asserted -> 4 frozen cycles, then one release cycle with mem_err = 1 (sticky), state RUN.
- Branch during wait: branch_taken = 1 while frozen -> no flush until mem_ack, then fd_flush = de_flush = 1 in the ack cycle.
- Reset mid-WAIT: rst low during wait cycle 2 -> all outputs 0 at once; after release, state RUN, mem_err 0, stall_cycles 0.
